// File: rtl/ahb_arbiter_core.sv
// ahb_arbiter_core: round-robin AHB bus arbiter with default master, fixed-burst and locked-sequence holding.
// Optional SPLIT masking (hsplit port, per-master mask) is compiled in when AHB_SPLIT_EN is defined.
module ahb_arbiter_core #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    input  logic [1:0]             hresp,
`ifdef AHB_SPLIT_EN
    input  logic [NUM_MASTERS-1:0] hsplit,
`endif
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [3:0]             hmaster,
    output logic                   hmastlock
);

    localparam logic [1:0]             HTRANS_IDLE   = 2'd0;
    localparam logic [1:0]             HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0]             HTRANS_SEQ    = 2'd3;
    localparam logic [1:0]             HRESP_OKAY    = 2'd0;
`ifdef AHB_SPLIT_EN
    localparam logic [1:0]             HRESP_SPLIT   = 2'd3;
`endif
    localparam logic [3:0]             DEFAULT_IDX   = 4'(DEFAULT_MASTER);
    localparam logic [15:0]            DEFAULT_OH16  = 16'd1 << DEFAULT_MASTER;
    localparam logic [NUM_MASTERS-1:0] DEFAULT_GRANT = DEFAULT_OH16[NUM_MASTERS-1:0];

    typedef enum logic [1:0] {
        ST_ARB,
        ST_BURST,
        ST_LOCKED
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             beat_cnt_q, beat_cnt_d;
    logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
    logic [3:0]             hmaster_q, hmaster_d;
    logic                   hmastlock_q, hmastlock_d;
`ifdef AHB_SPLIT_EN
    logic [NUM_MASTERS-1:0] split_mask_q, split_mask_d;
    logic [15:0]            mask16;
`endif

    logic [15:0] elig16, lock16, win_oh16;
    logic [3:0]  winner_idx, grant_idx, burst_len_m1;
    logic [4:0]  cand;
    logic        found, burst_start, rearb;

    // Vectors are widened to 16 bits so the 4-bit indices select without range issues.
    always_comb begin
`ifdef AHB_SPLIT_EN
        elig16 = 16'(hbusreq & ~split_mask_q);
`else
        elig16 = 16'(hbusreq);
`endif
        lock16     = 16'(hlock);
        winner_idx = DEFAULT_IDX;
        found      = 1'b0;
        cand       = 5'd0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = {1'b0, hmaster_q} + 5'(k);
            if (cand >= 5'(NUM_MASTERS)) begin
                cand = cand - 5'(NUM_MASTERS);
            end
            if (!found && elig16[cand[3:0]]) begin
                found      = 1'b1;
                winner_idx = cand[3:0];
            end
        end
        win_oh16  = 16'd1 << winner_idx;
        grant_idx = 4'd0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (hgrant_q[i]) begin
                grant_idx = 4'(i);
            end
        end
    end

    always_comb begin
        case (hburst)
            3'd2, 3'd3: burst_len_m1 = 4'd3;
            3'd4, 3'd5: burst_len_m1 = 4'd7;
            3'd6, 3'd7: burst_len_m1 = 4'd15;
            default:    burst_len_m1 = 4'd0;
        endcase
        burst_start = (htrans == HTRANS_NONSEQ) && (burst_len_m1 != 4'd0);
    end

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        hgrant_d    = hgrant_q;
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        rearb       = 1'b0;
`ifdef AHB_SPLIT_EN
        mask16      = 16'(split_mask_q);
`endif
        if (hready) begin
            hmaster_d   = grant_idx;
            hmastlock_d = lock16[grant_idx];
            // Beats are tracked in every state so a locked burst still counts down harmlessly.
            if (burst_start) begin
                beat_cnt_d = burst_len_m1;
            end else if (htrans == HTRANS_SEQ && beat_cnt_q != 4'd0) begin
                beat_cnt_d = beat_cnt_q - 4'd1;
            end
            case (state_q)
                ST_ARB:    rearb = 1'b1;
                ST_BURST:  rearb = (htrans == HTRANS_SEQ) && (beat_cnt_q == 4'd1);
                ST_LOCKED: rearb = !lock16[grant_idx] &&
                                   (htrans == HTRANS_IDLE || htrans == HTRANS_NONSEQ);
                default:   rearb = 1'b1;
            endcase
            if (rearb) begin
                if (lock16[winner_idx]) begin
                    hgrant_d = win_oh16[NUM_MASTERS-1:0];
                    state_d  = ST_LOCKED;
                end else if (state_q == ST_ARB && burst_start) begin
                    state_d  = ST_BURST;
                end else begin
                    hgrant_d = win_oh16[NUM_MASTERS-1:0];
                    state_d  = ST_ARB;
                end
            end
        end else if (hresp != HRESP_OKAY) begin
            // First cycle of a two-cycle response: abandon any fixed burst.
            beat_cnt_d = 4'd0;
            if (state_q == ST_BURST) begin
                state_d = ST_ARB;
            end
`ifdef AHB_SPLIT_EN
            if (hresp == HRESP_SPLIT) begin
                mask16[hmaster_q] = 1'b1;
                if (state_q == ST_LOCKED) begin
                    state_d = ST_ARB;
                end
            end
`endif
        end
`ifdef AHB_SPLIT_EN
        split_mask_d = mask16[NUM_MASTERS-1:0] & ~hsplit;
`endif
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q      <= ST_ARB;
            beat_cnt_q   <= 4'd0;
            hgrant_q     <= DEFAULT_GRANT;
            hmaster_q    <= DEFAULT_IDX;
            hmastlock_q  <= 1'b0;
`ifdef AHB_SPLIT_EN
            split_mask_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            hgrant_q     <= hgrant_d;
            hmaster_q    <= hmaster_d;
            hmastlock_q  <= hmastlock_d;
`ifdef AHB_SPLIT_EN
            split_mask_q <= split_mask_d;
`endif
        end
    end

    assign hgrant    = hgrant_q;
    assign hmaster   = hmaster_q;
    assign hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter_core.sv
// Directed bench for ahb_arbiter_core (4 masters, default master 0); expected values are hand-computed.
module tb_ahb_arbiter_core;

    logic       hclk = 1'b0;
    logic       hreset;
    logic [3:0] hbusreq, hlock, hsplit;
    logic [1:0] htrans, hresp;
    logic [2:0] hburst;
    logic       hready;
    logic [3:0] hgrant, hmaster;
    logic       hmastlock;

    int n_cmp = 0;
    int n_err = 0;

    ahb_arbiter_core #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hburst    (hburst),
        .hready    (hready),
        .hresp     (hresp),
`ifdef AHB_SPLIT_EN
        .hsplit    (hsplit),
`endif
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    always #5 hclk = ~hclk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic idle_inputs();
        hbusreq = 4'b0000;
        hlock   = 4'b0000;
        hsplit  = 4'b0000;
        htrans  = 2'd0;
        hburst  = 3'd0;
        hready  = 1'b1;
        hresp   = 2'd0;
    endtask

    task automatic do_reset();
        hreset = 1'b1;
        idle_inputs();
        tick();
        hreset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rr_g  [9];
        logic [3:0] rr_m  [9];
        logic [1:0] bt_tr [10];

        rr_g = '{4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0010};
        rr_m = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd0, 4'd0};
        bt_tr = '{2'd2, 2'd3, 2'd3, 2'd1, 2'd3, 2'd3, 2'd1, 2'd3, 2'd3, 2'd3};

        // Reset values
        hreset = 1'b1;
        idle_inputs();
        tick();
        tick();
        check_val("rst_hgrant", 32'(hgrant), 32'h1);
        check_val("rst_hmaster", 32'(hmaster), 32'h0);
        check_val("rst_hmastlock", 32'(hmastlock), 32'h0);
        hreset = 1'b0;

        // Round-robin with all masters requesting single transfers
        hbusreq = 4'b1111;
        htrans  = 2'd2;
        for (int e = 0; e < 9; e++) begin
            tick();
            check_val($sformatf("rr_grant_e%0d", e + 1), 32'(hgrant), 32'(rr_g[e]));
            check_val($sformatf("rr_master_e%0d", e + 1), 32'(hmaster), 32'(rr_m[e]));
        end
        hready = 1'b0;
        tick();
        check_val("rr_wait_grant", 32'(hgrant), 32'b0010);
        check_val("rr_wait_master", 32'(hmaster), 32'd0);

        // INCR8 held by M2 with two BUSY beats
        do_reset();
        hbusreq = 4'b0100;
        tick();
        tick();
        check_val("bt_setup_grant", 32'(hgrant), 32'b0100);
        check_val("bt_setup_master", 32'(hmaster), 32'd2);
        hbusreq = 4'b1111;
        hburst  = 3'd5;
        for (int b = 0; b < 10; b++) begin
            htrans = bt_tr[b];
            tick();
            check_val($sformatf("bt_grant_beat%0d", b + 1), 32'(hgrant), (b == 9) ? 32'b1000 : 32'b0100);
        end
        check_val("bt_master_end", 32'(hmaster), 32'd2);

        // Asynchronous reset in the middle of an INCR4
        do_reset();
        hbusreq = 4'b0100;
        tick();
        tick();
        htrans = 2'd2;
        hburst = 3'd3;
        tick();
        htrans = 2'd3;
        tick();
        check_val("ar_before_grant", 32'(hgrant), 32'b0100);
        hreset = 1'b1;
        #1;
        check_val("ar_async_grant", 32'(hgrant), 32'b0001);
        check_val("ar_async_master", 32'(hmaster), 32'd0);
        tick();
        hreset = 1'b0;
        htrans = 2'd3;
        tick();
        check_val("ar_after_grant", 32'(hgrant), 32'b0100);

        // Locked sequence from M1 while M0 and M3 request
        do_reset();
        hbusreq = 4'b1011;
        hlock   = 4'b0010;
        htrans  = 2'd2;
        tick();
        check_val("lk_e1_grant", 32'(hgrant), 32'b0010);
        check_val("lk_e1_mastlock", 32'(hmastlock), 32'd0);
        for (int t = 0; t < 3; t++) begin
            tick();
            check_val($sformatf("lk_xfer%0d_grant", t + 1), 32'(hgrant), 32'b0010);
            check_val($sformatf("lk_xfer%0d_master", t + 1), 32'(hmaster), 32'd1);
            check_val($sformatf("lk_xfer%0d_mastlock", t + 1), 32'(hmastlock), 32'd1);
        end
        hlock  = 4'b0000;
        htrans = 2'd3;
        tick();
        check_val("lk_drop_seq_grant", 32'(hgrant), 32'b0010);
        check_val("lk_drop_seq_mastlock", 32'(hmastlock), 32'd0);
        htrans = 2'd2;
        tick();
        check_val("lk_exit_grant", 32'(hgrant), 32'b1000);

        // INCR16 from M0 aborted by RETRY on beat 5
        do_reset();
        hbusreq = 4'b0001;
        htrans  = 2'd2;
        hburst  = 3'd7;
        tick();
        hbusreq = 4'b1001;
        htrans  = 2'd3;
        for (int b = 0; b < 3; b++) begin
            tick();
            check_val($sformatf("ab_hold_beat%0d", b + 2), 32'(hgrant), 32'b0001);
        end
        hready = 1'b0;
        hresp  = 2'd2;
        tick();
        check_val("ab_retry1_grant", 32'(hgrant), 32'b0001);
        hready = 1'b1;
        htrans = 2'd0;
        tick();
        check_val("ab_retry2_grant", 32'(hgrant), 32'b1000);
        hresp = 2'd0;
        tick();
        check_val("ab_m3_master", 32'(hmaster), 32'd3);
        tick();
        check_val("ab_m0_regrant", 32'(hgrant), 32'b0001);

`ifdef AHB_SPLIT_EN
        // SPLIT masks M2 until hsplit releases it
        do_reset();
        hbusreq = 4'b0101;
        htrans  = 2'd2;
        tick();
        tick();
        check_val("sp_setup_master", 32'(hmaster), 32'd2);
        hready = 1'b0;
        hresp  = 2'd3;
        tick();
        hready = 1'b1;
        htrans = 2'd0;
        tick();
        check_val("sp_skip_grant1", 32'(hgrant), 32'b0001);
        hresp  = 2'd0;
        htrans = 2'd2;
        tick();
        tick();
        check_val("sp_skip_grant2", 32'(hgrant), 32'b0001);
        hsplit = 4'b0100;
        tick();
        hsplit = 4'b0000;
        tick();
        check_val("sp_release_grant", 32'(hgrant), 32'b0100);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
